// File: rtl/bisr_output_row_writer_if.sv
// Bus between the systolic array / proxy columns, the output row writer and the output BRAM.
// Ports (signals):
//   start, fault_col_mask      run control and per-column source select
//   col_valid, col_data        array bottom outputs, column c at [c*WORD_SIZE +: WORD_SIZE]
//   proxy_valid, proxy_data    weight-proxy outputs, same packing
//   mem_addr, mem_wr_en,
//   mem_wr_data                output BRAM write port
//   busy, done, overflow_err   status
// Modports: master drives control and column data; slave is the row writer.
interface bisr_output_row_writer_if #(
    parameter int unsigned COLS           = 4,
    parameter int unsigned WORD_SIZE      = 16,
    parameter int unsigned MEM_PORT_WIDTH = 64
);
    logic                        start;
    logic [COLS-1:0]             fault_col_mask;
    logic [COLS-1:0]             col_valid;
    logic [COLS*WORD_SIZE-1:0]   col_data;
    logic [COLS-1:0]             proxy_valid;
    logic [COLS*WORD_SIZE-1:0]   proxy_data;
    logic [31:0]                 mem_addr;
    logic                        mem_wr_en;
    logic [MEM_PORT_WIDTH-1:0]   mem_wr_data;
    logic                        busy;
    logic                        done;
    logic                        overflow_err;

    modport master (
        output start, fault_col_mask, col_valid, col_data, proxy_valid, proxy_data,
        input  mem_addr, mem_wr_en, mem_wr_data, busy, done, overflow_err
    );

    modport slave (
        input  start, fault_col_mask, col_valid, col_data, proxy_valid, proxy_data,
        output mem_addr, mem_wr_en, mem_wr_data, busy, done, overflow_err
    );
endinterface

// File: rtl/bisr_output_row_writer.sv
// Collects skewed per-column results from the BISR systolic array and reassembles them into full
// rows, writing each completed row as one word to the output BRAM. Each column is sourced either
// from the array bottom output or from the weight-proxy output, chosen by a fault mask latched at
// start.
// Ports:
//   clk   system clock, all logic on posedge
//   rst   synchronous active-high reset
//   bus   slave side of bisr_output_row_writer_if (control, column data, BRAM write, status);
//         the interface must be instantiated with the same COLS/WORD_SIZE/MEM_PORT_WIDTH.
module bisr_output_row_writer #(
    parameter int unsigned ROWS           = 4,
    parameter int unsigned COLS           = 4,
    parameter int unsigned WORD_SIZE      = 16,
    parameter int unsigned MEM_PORT_WIDTH = 64,
    parameter logic [31:0] BASE_ADDR      = 32'd0
) (
    input logic                     clk,
    input logic                     rst,
    bisr_output_row_writer_if.slave bus
);
    localparam int unsigned CNT_W = $clog2(ROWS + 1);
    localparam int unsigned IDX_W = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int unsigned ROW_W = COLS * WORD_SIZE;

    if (MEM_PORT_WIDTH < ROW_W) begin : g_width_check
        $error("MEM_PORT_WIDTH must be at least COLS*WORD_SIZE");
    end

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e                    state_q, state_d;
    logic [COLS-1:0]           mask_q, mask_d;
    logic [CNT_W-1:0]          cnt_q [COLS];
    logic [CNT_W-1:0]          cnt_d [COLS];
    logic [CNT_W-1:0]          wr_row_q, wr_row_d;
    logic                      overflow_q, overflow_d;
    logic [31:0]               mem_addr_q, mem_addr_d;
    logic                      mem_wr_en_q, mem_wr_en_d;
    logic [MEM_PORT_WIDTH-1:0] mem_wr_data_q, mem_wr_data_d;
    logic [WORD_SIZE-1:0]      row_buf_q [ROWS][COLS];

    logic [COLS-1:0]           sel_valid;
    logic [WORD_SIZE-1:0]      sel_data [COLS];
    logic [COLS-1:0]           col_full;
    logic [COLS-1:0]           col_has_row;
    logic [COLS-1:0]           cap_en;
    logic                      run_cap;
    logic                      row_ready;
    logic [IDX_W-1:0]          rd_idx;
    logic [MEM_PORT_WIDTH-1:0] row_packed;

    // Per-column source select; the unselected source is ignored entirely.
    always_comb begin
        for (int c = 0; c < COLS; c++) begin
            sel_valid[c]   = mask_q[c] ? bus.proxy_valid[c] : bus.col_valid[c];
            sel_data[c]    = mask_q[c] ? bus.proxy_data[c*WORD_SIZE +: WORD_SIZE]
                                       : bus.col_data[c*WORD_SIZE +: WORD_SIZE];
            col_full[c]    = (cnt_q[c] == CNT_W'(ROWS));
            col_has_row[c] = (cnt_q[c] > wr_row_q);
        end
    end

    // No capture in the start cycle: state is being cleared.
    assign run_cap   = (state_q == StRun) && !bus.start;
    assign cap_en    = {COLS{run_cap}} & sel_valid & ~col_full;
    // Evaluated on registered counters, giving one bubble between capture and write.
    assign row_ready = (state_q == StRun) && (&col_has_row);
    assign rd_idx    = wr_row_q[IDX_W-1:0];

    always_comb begin
        row_packed = '0;
        for (int c = 0; c < COLS; c++) begin
            row_packed[c*WORD_SIZE +: WORD_SIZE] = row_buf_q[rd_idx][c];
        end
    end

    always_comb begin
        state_d       = state_q;
        mask_d        = mask_q;
        cnt_d         = cnt_q;
        wr_row_d      = wr_row_q;
        overflow_d    = overflow_q;
        mem_wr_en_d   = 1'b0;
        mem_addr_d    = mem_addr_q;
        mem_wr_data_d = mem_wr_data_q;

        case (state_q)
            StIdle: begin
            end
            StRun: begin
                for (int c = 0; c < COLS; c++) begin
                    if (cap_en[c]) begin
                        cnt_d[c] = cnt_q[c] + CNT_W'(1);
                    end
                end
                if (|(sel_valid & col_full)) begin
                    overflow_d = 1'b1;
                end
                if (row_ready) begin
                    mem_wr_en_d   = 1'b1;
                    mem_addr_d    = BASE_ADDR + 32'(wr_row_q);
                    mem_wr_data_d = row_packed;
                    wr_row_d      = wr_row_q + CNT_W'(1);
                end
                if (wr_row_q == CNT_W'(ROWS)) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        // Start restarts from any state; partly collected rows are abandoned.
        if (bus.start) begin
            state_d     = StRun;
            mask_d      = bus.fault_col_mask;
            wr_row_d    = '0;
            overflow_d  = 1'b0;
            mem_wr_en_d = 1'b0;
            for (int c = 0; c < COLS; c++) begin
                cnt_d[c] = '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= StIdle;
            mask_q        <= '0;
            wr_row_q      <= '0;
            overflow_q    <= 1'b0;
            mem_addr_q    <= '0;
            mem_wr_en_q   <= 1'b0;
            mem_wr_data_q <= '0;
            for (int c = 0; c < COLS; c++) begin
                cnt_q[c] <= '0;
            end
        end else begin
            state_q       <= state_d;
            mask_q        <= mask_d;
            wr_row_q      <= wr_row_d;
            overflow_q    <= overflow_d;
            mem_addr_q    <= mem_addr_d;
            mem_wr_en_q   <= mem_wr_en_d;
            mem_wr_data_q <= mem_wr_data_d;
            for (int c = 0; c < COLS; c++) begin
                cnt_q[c] <= cnt_d[c];
            end
        end
    end

    // Row buffer: contents are don't-care after reset, so no reset term.
    always_ff @(posedge clk) begin
        for (int c = 0; c < COLS; c++) begin
            if (cap_en[c]) begin
                row_buf_q[cnt_q[c][IDX_W-1:0]][c] <= sel_data[c];
            end
        end
    end

    assign bus.mem_addr     = mem_addr_q;
    assign bus.mem_wr_en    = mem_wr_en_q;
    assign bus.mem_wr_data  = mem_wr_data_q;
    assign bus.busy         = (state_q == StRun);
    assign bus.done         = (state_q == StDone);
    assign bus.overflow_err = overflow_q;
endmodule

// File: tb/tb_bisr_output_row_writer.sv
// Directed bench for bisr_output_row_writer: skewed capture, proxy substitution, stall,
// overflow, restart and mid-run reset.
module tb_bisr_output_row_writer;
    localparam int ROWS = 4;
    localparam int COLS = 4;
    localparam int WS   = 16;
    localparam int MW   = 64;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    bisr_output_row_writer_if #(.COLS(COLS), .WORD_SIZE(WS), .MEM_PORT_WIDTH(MW)) bus_if ();

    bisr_output_row_writer #(
        .ROWS(ROWS), .COLS(COLS), .WORD_SIZE(WS), .MEM_PORT_WIDTH(MW), .BASE_ADDR(32'd0)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus_if)
    );

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Write / done log, sampled mid-cycle.
    logic [31:0] wr_addr [256];
    logic [63:0] wr_data [256];
    int          wr_cyc  [256];
    int          nwr      = 0;
    int          done_cnt = 0;
    int          done_cyc = 0;

    always @(negedge clk) begin
        if (bus_if.mem_wr_en === 1'b1 && nwr < 256) begin
            wr_addr[nwr] = bus_if.mem_addr;
            wr_data[nwr] = bus_if.mem_wr_data;
            wr_cyc[nwr]  = cyc;
            nwr          = nwr + 1;
        end
        if (bus_if.done === 1'b1) begin
            done_cnt = done_cnt + 1;
            done_cyc = cyc;
        end
    end

    int off [4];

    function automatic logic [15:0] elem(input int r, input int c);
        logic [15:0] row0 [4];
        row0 = '{16'd67, 16'd43, 16'd81, 16'd23};
        if (r == 0) return row0[c];
        return 16'(100 * r + 10 * c + 1);
    endfunction

    function automatic logic [63:0] exp_row(input int r);
        logic [63:0] v;
        v = '0;
        for (int c = 0; c < COLS; c++) v[c*16 +: 16] = elem(r, c);
        return v;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        bus_if.col_valid   = '0;
        bus_if.col_data    = '0;
        bus_if.proxy_valid = '0;
        bus_if.proxy_data  = '0;
    endtask

    task automatic do_start(input logic [3:0] mask);
        bus_if.fault_col_mask = mask;
        bus_if.start          = 1'b1;
        tick();
        bus_if.start = 1'b0;
    endtask

    // Column c emits row r at drive cycle off[c]+r; dead2 floods array col 2 with 0xDEAD;
    // extra1 adds a fifth valid on array col 1.
    task automatic drive(input logic [3:0] mask, input int ncyc, input bit extra1, input bit dead2);
        for (int k = 0; k < ncyc; k++) begin
            clear_inputs();
            for (int c = 0; c < COLS; c++) begin
                int r;
                r = k - off[c];
                if (r >= 0 && r < ROWS) begin
                    if (mask[c]) begin
                        bus_if.proxy_valid[c]          = 1'b1;
                        bus_if.proxy_data[c*16 +: 16]  = elem(r, c);
                    end else begin
                        bus_if.col_valid[c]            = 1'b1;
                        bus_if.col_data[c*16 +: 16]    = elem(r, c);
                    end
                end
            end
            if (dead2) begin
                bus_if.col_valid[2]     = 1'b1;
                bus_if.col_data[47:32]  = 16'hDEAD;
            end
            if (extra1 && k == off[1] + 4) begin
                bus_if.col_valid[1]     = 1'b1;
                bus_if.col_data[31:16]  = 16'hBEEF;
            end
            tick();
        end
        clear_inputs();
    endtask

    task automatic wait_done(input int base, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 80; i++) begin
            @(negedge clk);
            #1;
            if (done_cnt > base) begin
                ok = 1'b1;
                break;
            end
        end
        tick();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
        tick();
        checks++; if (bus_if.mem_addr !== 32'd0) begin errors++;
            $display("FAIL reset_addr: got %h want 0", bus_if.mem_addr); end
        checks++; if (bus_if.mem_wr_en !== 1'b0) begin errors++;
            $display("FAIL reset_wr_en: got %b want 0", bus_if.mem_wr_en); end
        checks++; if (bus_if.mem_wr_data !== 64'd0) begin errors++;
            $display("FAIL reset_data: got %h want 0", bus_if.mem_wr_data); end
        checks++; if (bus_if.busy !== 1'b0) begin errors++;
            $display("FAIL reset_busy: got %b want 0", bus_if.busy); end
        checks++; if (bus_if.done !== 1'b0) begin errors++;
            $display("FAIL reset_done: got %b want 0", bus_if.done); end
        checks++; if (bus_if.overflow_err !== 1'b0) begin errors++;
            $display("FAIL reset_ovf: got %b want 0", bus_if.overflow_err); end
    endtask

    task automatic test_clean_skew();
        int wb, db, s0;
        bit ok;
        wb = nwr; db = done_cnt;
        off = '{0, 1, 2, 3};
        do_start(4'b0000);
        s0 = cyc;
        checks++; if (bus_if.busy !== 1'b1) begin errors++;
            $display("FAIL skew_busy: got %b want 1", bus_if.busy); end
        drive(4'b0000, 7, 1'b0, 1'b0);
        wait_done(db, ok);
        checks++; if (ok !== 1'b1) begin errors++;
            $display("FAIL skew_done_timeout: got %b want 1", ok); end
        repeat (3) tick();
        checks++; if (nwr - wb !== 4) begin errors++;
            $display("FAIL skew_nwr: got %0d want 4", nwr - wb); end
        for (int r = 0; r < ROWS; r++) begin
            checks++; if (wr_addr[wb+r] !== 32'(r)) begin errors++;
                $display("FAIL skew_addr%0d: got %h want %h", r, wr_addr[wb+r], r); end
            checks++; if (wr_data[wb+r] !== exp_row(r)) begin errors++;
                $display("FAIL skew_data%0d: got %h want %h", r, wr_data[wb+r], exp_row(r)); end
            checks++; if (wr_cyc[wb+r] !== s0 + 5 + r) begin errors++;
                $display("FAIL skew_cyc%0d: got %0d want %0d", r, wr_cyc[wb+r], s0 + 5 + r); end
        end
        checks++; if (wr_data[wb] !== 64'h0017_0051_002B_0043) begin errors++;
            $display("FAIL skew_row0_lit: got %h want 0017_0051_002b_0043", wr_data[wb]); end
        checks++; if (done_cnt - db !== 1) begin errors++;
            $display("FAIL skew_done_cnt: got %0d want 1", done_cnt - db); end
        checks++; if (done_cyc !== s0 + 9) begin errors++;
            $display("FAIL skew_done_cyc: got %0d want %0d", done_cyc, s0 + 9); end
        checks++; if (bus_if.busy !== 1'b0) begin errors++;
            $display("FAIL skew_busy_end: got %b want 0", bus_if.busy); end
    endtask

    task automatic test_proxy();
        int wb, db;
        bit ok;
        wb = nwr; db = done_cnt;
        off = '{0, 1, 2, 3};
        do_start(4'b0100);
        drive(4'b0100, 7, 1'b0, 1'b1);
        wait_done(db, ok);
        checks++; if (ok !== 1'b1) begin errors++;
            $display("FAIL proxy_done_timeout: got %b want 1", ok); end
        checks++; if (nwr - wb !== 4) begin errors++;
            $display("FAIL proxy_nwr: got %0d want 4", nwr - wb); end
        for (int r = 0; r < ROWS; r++) begin
            checks++; if (wr_data[wb+r] !== exp_row(r)) begin errors++;
                $display("FAIL proxy_data%0d: got %h want %h", r, wr_data[wb+r], exp_row(r)); end
            for (int c = 0; c < COLS; c++) begin
                checks++; if (wr_data[wb+r][c*16 +: 16] === 16'hDEAD) begin errors++;
                    $display("FAIL proxy_dead_r%0dc%0d: got dead want %h", r, c, elem(r, c)); end
            end
        end
        checks++; if (bus_if.overflow_err !== 1'b0) begin errors++;
            $display("FAIL proxy_ovf: got %b want 0", bus_if.overflow_err); end
    endtask

    task automatic test_stall();
        int wb, db, s0;
        bit ok;
        wb = nwr; db = done_cnt;
        off = '{0, 1, 2, 16};
        do_start(4'b0000);
        s0 = cyc;
        drive(4'b0000, 20, 1'b0, 1'b0);
        wait_done(db, ok);
        checks++; if (ok !== 1'b1) begin errors++;
            $display("FAIL stall_done_timeout: got %b want 1", ok); end
        checks++; if (nwr - wb !== 4) begin errors++;
            $display("FAIL stall_nwr: got %0d want 4", nwr - wb); end
        for (int r = 0; r < ROWS; r++) begin
            checks++; if (wr_cyc[wb+r] !== s0 + 18 + r) begin errors++;
                $display("FAIL stall_cyc%0d: got %0d want %0d", r, wr_cyc[wb+r], s0 + 18 + r); end
            checks++; if (wr_data[wb+r] !== exp_row(r)) begin errors++;
                $display("FAIL stall_data%0d: got %h want %h", r, wr_data[wb+r], exp_row(r)); end
        end
        checks++; if (done_cyc !== s0 + 22) begin errors++;
            $display("FAIL stall_done_cyc: got %0d want %0d", done_cyc, s0 + 22); end
    endtask

    task automatic test_overflow();
        int wb, db;
        bit ok;
        wb = nwr; db = done_cnt;
        off = '{0, 1, 2, 3};
        do_start(4'b0000);
        checks++; if (bus_if.overflow_err !== 1'b0) begin errors++;
            $display("FAIL ovf_pre: got %b want 0", bus_if.overflow_err); end
        drive(4'b0000, 7, 1'b1, 1'b0);
        checks++; if (bus_if.overflow_err !== 1'b1) begin errors++;
            $display("FAIL ovf_set: got %b want 1", bus_if.overflow_err); end
        wait_done(db, ok);
        checks++; if (ok !== 1'b1) begin errors++;
            $display("FAIL ovf_done_timeout: got %b want 1", ok); end
        repeat (5) tick();
        checks++; if (bus_if.overflow_err !== 1'b1) begin errors++;
            $display("FAIL ovf_sticky: got %b want 1", bus_if.overflow_err); end
        for (int r = 0; r < ROWS; r++) begin
            checks++; if (wr_data[wb+r] !== exp_row(r)) begin errors++;
                $display("FAIL ovf_data%0d: got %h want %h", r, wr_data[wb+r], exp_row(r)); end
        end
    endtask

    task automatic test_restart();
        int wb, wb2, db;
        bit ok;
        wb = nwr; db = done_cnt;
        off = '{0, 1, 2, 3};
        do_start(4'b0000);
        drive(4'b0000, 6, 1'b1, 1'b0);
        @(negedge clk);
        #1;
        checks++; if (nwr - wb !== 2) begin errors++;
            $display("FAIL restart_first_nwr: got %0d want 2", nwr - wb); end
        checks++; if (bus_if.overflow_err !== 1'b1) begin errors++;
            $display("FAIL restart_ovf_before: got %b want 1", bus_if.overflow_err); end
        do_start(4'b0000);
        checks++; if (bus_if.overflow_err !== 1'b0) begin errors++;
            $display("FAIL restart_ovf_clear: got %b want 0", bus_if.overflow_err); end
        checks++; if (bus_if.mem_wr_en !== 1'b0) begin errors++;
            $display("FAIL restart_start_wr: got %b want 0", bus_if.mem_wr_en); end
        wb2 = nwr + 1;
        drive(4'b0000, 7, 1'b0, 1'b0);
        wait_done(db, ok);
        checks++; if (ok !== 1'b1) begin errors++;
            $display("FAIL restart_done_timeout: got %b want 1", ok); end
        repeat (3) tick();
        checks++; if (nwr - wb !== 6) begin errors++;
            $display("FAIL restart_total_nwr: got %0d want 6", nwr - wb); end
        for (int r = 0; r < ROWS; r++) begin
            checks++; if (wr_addr[wb2-1+r] !== 32'(r)) begin errors++;
                $display("FAIL restart_addr%0d: got %h want %h", r, wr_addr[wb2-1+r], r); end
            checks++; if (wr_data[wb2-1+r] !== exp_row(r)) begin errors++;
                $display("FAIL restart_data%0d: got %h want %h", r, wr_data[wb2-1+r], exp_row(r)); end
        end
        checks++; if (done_cnt - db !== 1) begin errors++;
            $display("FAIL restart_done_cnt: got %0d want 1", done_cnt - db); end
    endtask

    task automatic test_reset_mid_run();
        int wb, db;
        wb = nwr; db = done_cnt;
        off = '{0, 1, 2, 3};
        do_start(4'b0000);
        drive(4'b0000, 4, 1'b0, 1'b0);
        rst = 1'b1;
        tick();
        checks++; if (bus_if.mem_wr_en !== 1'b0) begin errors++;
            $display("FAIL midrst_wr_en: got %b want 0", bus_if.mem_wr_en); end
        checks++; if (bus_if.busy !== 1'b0) begin errors++;
            $display("FAIL midrst_busy: got %b want 0", bus_if.busy); end
        checks++; if (bus_if.done !== 1'b0) begin errors++;
            $display("FAIL midrst_done: got %b want 0", bus_if.done); end
        rst = 1'b0;
        drive(4'b0000, 7, 1'b0, 1'b0);
        repeat (5) tick();
        checks++; if (nwr - wb !== 0) begin errors++;
            $display("FAIL midrst_nwr: got %0d want 0", nwr - wb); end
        checks++; if (done_cnt - db !== 0) begin errors++;
            $display("FAIL midrst_done_cnt: got %0d want 0", done_cnt - db); end
        checks++; if (bus_if.busy !== 1'b0) begin errors++;
            $display("FAIL midrst_busy_after: got %b want 0", bus_if.busy); end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, checks %0d errors %0d", checks, errors);
        $fatal(1, "watchdog");
    end

    initial begin
        bus_if.start          = 1'b0;
        bus_if.fault_col_mask = '0;
        clear_inputs();
        test_reset();
        test_clean_skew();
        test_proxy();
        test_stall();
        test_overflow();
        test_restart();
        test_reset_mid_run();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
